// File: rtl/ttt_turn_controller.sv
// Two-player tic-tac-toe turn sequencer: takes keypad moves, keeps the 18-bit board,
// judges win/draw and enforces an optional per-turn timeout.
module ttt_turn_controller #(
    parameter int unsigned TURN_TIMEOUT = 250000000,
    parameter int unsigned TIMER_W      = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        key_valid,
    input  logic [3:0]  key_data,
    output logic [17:0] board,
    output logic        is_turn_o,
    output logic [1:0]  result,
    output logic [3:0]  move_count,
    output logic        in_game,
    output logic        reject,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE, WAIT_KEY, CHECK, WRITE, JUDGE, SWAP, OVER
    } state_t;

    localparam bit TO_EN = (TURN_TIMEOUT != 0);
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'(TO_EN ? TURN_TIMEOUT - 32'd1 : 32'd0);

    state_t               state;
    logic [3:0]           cell_idx;
    logic [TIMER_W-1:0]   timer;

    logic [8:0] x_plane, o_plane, cell_hot, x_next, o_next, cur_plane;
    logic       timer_last, occupied, key_ok;

    // Plane bit i is cell i+1; X of cell k sits at board bit 18-2k, O one above it.
    function automatic logic [8:0] plane_x(input logic [17:0] b);
        return {b[0], b[2], b[4], b[6], b[8], b[10], b[12], b[14], b[16]};
    endfunction

    function automatic logic [8:0] plane_o(input logic [17:0] b);
        return {b[1], b[3], b[5], b[7], b[9], b[11], b[13], b[15], b[17]};
    endfunction

    function automatic logic [17:0] pack_board(input logic [8:0] x, input logic [8:0] o);
        return {o[0], x[0], o[1], x[1], o[2], x[2], o[3], x[3], o[4], x[4],
                o[5], x[5], o[6], x[6], o[7], x[7], o[8], x[8]};
    endfunction

    function automatic logic has_line(input logic [8:0] c);
        return (c[0] & c[1] & c[2]) | (c[3] & c[4] & c[5]) | (c[6] & c[7] & c[8]) |
               (c[0] & c[3] & c[6]) | (c[1] & c[4] & c[7]) | (c[2] & c[5] & c[8]) |
               (c[0] & c[4] & c[8]) | (c[2] & c[4] & c[6]);
    endfunction

    always_comb begin
        x_plane    = plane_x(board);
        o_plane    = plane_o(board);
        cell_hot   = 9'd1 << cell_idx;
        occupied   = |((x_plane | o_plane) & cell_hot);
        x_next     = is_turn_o ? x_plane : (x_plane | cell_hot);
        o_next     = is_turn_o ? (o_plane | cell_hot) : o_plane;
        cur_plane  = is_turn_o ? o_plane : x_plane;
        key_ok     = (key_data != 4'd0) && (key_data <= 4'd9);
        // The timer saturates at its last value so an expiry reached during CHECK
        // is still pending when control returns to WAIT_KEY.
        timer_last = TO_EN && (timer == TIMER_LAST);
    end

    always_ff @(posedge clk) begin
        reject  <= 1'b0;
        timeout <= 1'b0;
        if (rst) begin
            state      <= IDLE;
            board      <= '0;
            is_turn_o  <= 1'b0;
            result     <= 2'b00;
            move_count <= 4'd0;
            in_game    <= 1'b0;
            timer      <= '0;
            cell_idx   <= 4'd0;
        end else if (start) begin
            state      <= WAIT_KEY;
            board      <= '0;
            is_turn_o  <= 1'b0;
            result     <= 2'b00;
            move_count <= 4'd0;
            in_game    <= 1'b1;
            timer      <= '0;
        end else begin
            case (state)
                IDLE: ;
                WAIT_KEY: begin
                    if (!timer_last) timer <= timer + 1'b1;
                    if (key_valid) begin
                        if (key_ok) begin
                            cell_idx <= key_data - 4'd1;
                            state    <= CHECK;
                        end else begin
                            reject <= 1'b1;
                        end
                    end else if (timer_last) begin
                        timeout   <= 1'b1;
                        is_turn_o <= ~is_turn_o;
                        timer     <= '0;
                    end
                end
                CHECK: begin
                    if (!timer_last) timer <= timer + 1'b1;
                    if (occupied) begin
                        reject <= 1'b1;
                        state  <= WAIT_KEY;
                    end else begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    board      <= pack_board(x_next, o_next);
                    move_count <= move_count + 4'd1;
                    state      <= JUDGE;
                end
                JUDGE: begin
                    if (has_line(cur_plane)) begin
                        result  <= is_turn_o ? 2'b10 : 2'b01;
                        in_game <= 1'b0;
                        state   <= OVER;
                    end else if (move_count == 4'd9) begin
                        result  <= 2'b11;
                        in_game <= 1'b0;
                        state   <= OVER;
                    end else begin
                        state <= SWAP;
                    end
                end
                SWAP: begin
                    is_turn_o <= ~is_turn_o;
                    timer     <= '0;
                    state     <= WAIT_KEY;
                end
                OVER: ;
                default: begin
                    state   <= IDLE;
                    in_game <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Random and directed game play against a cell-array game model of the turn controller.
module tb_ttt_turn_controller;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst, start, key_valid;
    logic [3:0]  key_data;
    logic [17:0] board;
    logic        is_turn_o, in_game, reject, timeout;
    logic [1:0]  result;
    logic [3:0]  move_count;

    ttt_turn_controller #(.TURN_TIMEOUT(TO), .TIMER_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_data(key_data),
        .board(board), .is_turn_o(is_turn_o), .result(result), .move_count(move_count),
        .in_game(in_game), .reject(reject), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // Game model: cells 0 empty, 1 X, 2 O; m_stage counts cycles into a move (0 = waiting)
    int m_cell[9];
    int m_turn, m_res, m_cnt, m_stage, m_sel, m_el;
    bit m_act, m_rej, m_to;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic bit wins(input int who);
        for (int l = 0; l < 8; l++)
            if (m_cell[lines[l][0]] == who && m_cell[lines[l][1]] == who &&
                m_cell[lines[l][2]] == who) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [17:0] exp_board();
        logic [17:0] b;
        b = '0;
        for (int k = 1; k <= 9; k++) begin
            if (m_cell[k-1] == 1) b[18-2*k] = 1'b1;
            if (m_cell[k-1] == 2) b[19-2*k] = 1'b1;
        end
        return b;
    endfunction

    always @(posedge clk) begin
        m_rej = 0;
        m_to  = 0;
        if (rst || start) begin
            for (int i = 0; i < 9; i++) m_cell[i] = 0;
            m_turn = 0; m_res = 0; m_cnt = 0; m_stage = 0; m_el = 0;
            m_act = !rst;
        end else if (m_act) begin
            case (m_stage)
                0: if (key_valid) begin
                       m_el++;
                       if (key_data >= 1 && key_data <= 9) begin
                           m_sel = int'(key_data) - 1;
                           m_stage = 1;
                       end else m_rej = 1;
                   end else if (TO != 0 && m_el >= TO - 1) begin
                       m_to = 1; m_turn = 1 - m_turn; m_el = 0;
                   end else m_el++;
                1: begin
                       m_el++;
                       if (m_cell[m_sel] != 0) begin m_rej = 1; m_stage = 0; end
                       else m_stage = 2;
                   end
                2: begin m_cell[m_sel] = m_turn + 1; m_cnt++; m_stage = 3; end
                3: if (wins(m_turn + 1)) begin m_res = m_turn + 1; m_act = 0; end
                   else if (m_cnt == 9) begin m_res = 3; m_act = 0; end
                   else m_stage = 4;
                default: begin m_turn = 1 - m_turn; m_el = 0; m_stage = 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [27:0] got, want;
            got  = {board, is_turn_o, result, move_count, in_game, reject, timeout};
            want = {exp_board(), m_turn[0], m_res[1:0], m_cnt[3:0], m_act, m_rej, m_to};
            total++;
            if (got !== want || (reject && timeout)) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got=%h want=%h (board,turn,res,cnt,in_game,rej,to)",
                         $time, got, want);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input int k);
        key_valid = 1'b1;
        key_data  = 4'(k);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic play(input int k);
        key(k);
        idle(4);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int draw_seq[9];
        int xwin_seq[9];
        int pk;
        draw_seq = '{1,2,3,5,4,6,8,7,9};
        xwin_seq = '{1,2,3,4,8,6,9,7,5};
        rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_data = 4'd0;
        idle(2);
        chk_en = 1;
        lit("reset_board", board, 0);
        lit("reset_result", result, 0);
        lit("reset_in_game", in_game, 0);
        rst = 1'b0;
        idle(2);

        pulse_start();
        key(0);  lit("badkey0_reject", reject, 1);
        key(12); lit("badkey12_reject", reject, 1);
        idle(2);

        pulse_start();
        play(1); play(4); play(2); play(5); play(3);
        lit("xrow_board", board, 18'h15A00);
        lit("xrow_result", result, 2'b01);
        lit("xrow_count", move_count, 5);
        lit("xrow_in_game", in_game, 0);
        play(7);
        lit("over_board_held", board, 18'h15A00);

        pulse_start();
        play(5);
        key(5); idle(1);
        lit("occupied_reject", reject, 1);
        lit("occupied_board", board, 18'h00100);
        lit("occupied_turn", is_turn_o, 1);
        idle(2);

        pulse_start();
        for (int i = 0; i < 9; i++) play(draw_seq[i]);
        lit("draw_result", result, 2'b11);
        lit("draw_count", move_count, 9);

        pulse_start();
        for (int i = 0; i < 9; i++) play(xwin_seq[i]);
        lit("xwin9_result", result, 2'b01);
        lit("xwin9_board", board, 18'h199A5);

        pulse_start();
        idle(19); lit("pre_timeout", timeout, 0);
        idle(1);
        lit("timeout_pulse", timeout, 1);
        lit("timeout_turn", is_turn_o, 1);
        lit("timeout_board", board, 0);
        idle(19);
        key(9);
        lit("expiry_key_no_timeout", timeout, 0);
        idle(4);
        lit("expiry_key_board", board, 18'h00002);
        lit("expiry_key_turn", is_turn_o, 0);

        pulse_start();
        play(1); play(2); play(3);
        pulse_start();
        lit("restart_board", board, 0);
        lit("restart_count", move_count, 0);
        lit("restart_turn", is_turn_o, 0);
        lit("restart_in_game", in_game, 1);
        key(4); idle(2);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        lit("judge_rst_board", board, 0);
        lit("judge_rst_count", move_count, 0);
        lit("judge_rst_in_game", in_game, 0);

        for (int blk = 0; blk < 6; blk++) begin
            pk = (blk % 2 == 0) ? 3 : 40;
            for (int c = 0; c < 800; c++) begin
                key_valid = ($urandom_range(pk - 1) == 0);
                key_data  = ($urandom_range(7) == 0) ? 4'($urandom_range(15))
                                                     : 4'($urandom_range(9, 1));
                start     = (!m_act && $urandom_range(9) == 0) || ($urandom_range(499) == 0);
                rst       = ($urandom_range(1499) == 0);
                @(negedge clk);
            end
        end
        key_valid = 1'b0; start = 1'b0; rst = 1'b0;
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
